// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the LED pattern generator.
// Counter widths up to CFG_W bits are supported.
package led_pattern_pkg;

    localparam int unsigned CH_IDX_W = 4;
    localparam int unsigned CFG_W    = 32;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e            mode;
        logic [CFG_W-1:0] period;
        logic [CFG_W-1:0] duty;
    } cfg_t;

    localparam int unsigned CFG_BITS = $bits(cfg_t);

    // A programmed period of 0 behaves as a period of 1.
    function automatic logic [CFG_W-1:0] last_count(input logic [CFG_W-1:0] period);
        return (period == '0) ? '0 : period - 1'b1;
    endfunction

endpackage

// File: rtl/led_pattern_channel.sv
// One LED channel: period counter, double-buffered configuration and registered LED/wrap outputs.
// Shadow settings move to the active set only at a safe point, so the LED never glitches.
module led_pattern_channel
    import led_pattern_pkg::*;
#(
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 25000000
) (
    input  logic                pi_clk,
    input  logic                pi_rst,
    input  logic                pi_wr_en,
    input  logic [CFG_BITS-1:0] pi_cfg,
    input  logic                pi_sync,
    output logic                po_pending,
    output logic                po_led,
    output logic                po_wrap
);

    cfg_t             act_q, act_d;
    cfg_t             sh_q, sh_d;
    cfg_t             reset_cfg;
    cfg_t             wr_cfg;
    logic             pend_q, pend_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             led_q, led_d;
    logic             wrap_q, wrap_d;
    logic             wrap;
    logic             apply;
    logic             static_mode;

    assign reset_cfg = '{mode: MODE_BLINK, period: CFG_W'(DEFAULT_PERIOD), duty: '0};
    assign wr_cfg    = cfg_t'(pi_cfg);
    assign wrap      = (CFG_W'(cnt_q) == last_count(act_q.period));

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            act_q   <= reset_cfg;
            sh_q    <= reset_cfg;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            led_q   <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            act_q   <= act_d;
            sh_q    <= sh_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            led_q   <= led_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path can infer a latch.
        act_d       = act_q;
        sh_d        = sh_q;
        pend_d      = pend_q;
        cnt_d       = cnt_q + 1'b1;
        level_d     = level_q;
        wrap_d      = wrap;
        led_d       = 1'b0;
        static_mode = (act_q.mode == MODE_OFF) || (act_q.mode == MODE_ON);

        // Sync overrides a coincident wrap: no pulse, no toggle, level restarts low.
        if (pi_sync) begin
            cnt_d   = '0;
            level_d = 1'b0;
            wrap_d  = 1'b0;
        end else if (wrap) begin
            cnt_d = '0;
            if (act_q.mode == MODE_BLINK) begin
                level_d = ~level_q;
            end
        end

        case (act_q.mode)
            MODE_OFF:   led_d = 1'b0;
            MODE_ON:    led_d = 1'b1;
            MODE_BLINK: led_d = level_d;
            MODE_PWM:   led_d = (CFG_W'(cnt_q) < act_q.duty);
            default:    led_d = 1'b0;
        endcase

        // Level is deliberately left alone on apply so a BLINK pattern continues seamlessly.
        apply = pend_q && (pi_sync || static_mode || wrap);
        if (apply) begin
            act_d  = sh_q;
            cnt_d  = '0;
            pend_d = 1'b0;
        end

        if (pi_wr_en) begin
            sh_d   = wr_cfg;
            pend_d = 1'b1;
        end
    end

    assign po_pending = pend_q;
    assign po_led     = led_q;
    assign po_wrap    = wrap_q;

endmodule

// File: rtl/led_pattern_generator.sv
// Multi-channel LED pattern generator: write decode, per-channel ready and error pulse.
// Define LED_PATTERN_SYNC_EN to add pi_sync, which phase-aligns all channels.
module led_pattern_generator
    import led_pattern_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned CNT_W          = 32,
    parameter int unsigned DEFAULT_PERIOD = 25000000
) (
    input  logic                pi_clk,
    input  logic                pi_rst,
`ifdef LED_PATTERN_SYNC_EN
    input  logic                pi_sync,
`endif
    input  logic                pi_cfg_valid,
    output logic                po_cfg_ready,
    input  logic [CH_IDX_W-1:0] pi_cfg_ch,
    input  logic [1:0]          pi_cfg_mode,
    input  logic [CNT_W-1:0]    pi_cfg_period,
    input  logic [CNT_W-1:0]    pi_cfg_duty,
    output logic                po_cfg_err,
    output logic [NUM_CH-1:0]   po_led,
    output logic [NUM_CH-1:0]   po_wrap
);

    logic              sync;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] wr_en;
    logic              ch_in_range;
    logic              accept;
    logic              err_q, err_d;
    cfg_t              wr_cfg;

`ifdef LED_PATTERN_SYNC_EN
    assign sync = pi_sync;
`else
    assign sync = 1'b0;
`endif

    // Out-of-range indices are always ready so their writes can be flagged rather than stall.
    always_comb begin
        ch_in_range  = 1'b0;
        po_cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (pi_cfg_ch == CH_IDX_W'(i)) begin
                ch_in_range  = 1'b1;
                po_cfg_ready = ~pending[i];
            end
        end
    end

    assign accept = pi_cfg_valid && po_cfg_ready;
    assign err_d  = accept && !ch_in_range;
    assign wr_cfg = '{mode:   mode_e'(pi_cfg_mode),
                      period: CFG_W'(pi_cfg_period),
                      duty:   CFG_W'(pi_cfg_duty)};

    always_comb begin
        wr_en = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_en[i] = accept && (pi_cfg_ch == CH_IDX_W'(i));
        end
    end

    always_ff @(posedge pi_clk) begin
        if (pi_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign po_cfg_err = err_q;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        led_pattern_channel #(
            .CNT_W          (CNT_W),
            .DEFAULT_PERIOD (DEFAULT_PERIOD)
        ) u_ch (
            .pi_clk     (pi_clk),
            .pi_rst     (pi_rst),
            .pi_wr_en   (wr_en[g]),
            .pi_cfg     (wr_cfg),
            .pi_sync    (sync),
            .po_pending (pending[g]),
            .po_led     (po_led[g]),
            .po_wrap    (po_wrap[g])
        );
    end

endmodule

// File: tb/tb_led_pattern_generator.sv
// Self-checking bench for led_pattern_generator: a reference model derives every LED/wrap
// value from elapsed cycles since each channel's last restart. LED_PATTERN_SYNC_EN adds sync tests.
module tb_led_pattern_generator;

    localparam int NUM_CH  = 4;
    localparam int CNT_W   = 32;
    localparam int DEF_PER = 5;
    localparam int M_OFF   = 0;
    localparam int M_ON    = 1;
    localparam int M_BLINK = 2;
    localparam int M_PWM   = 3;

    logic              pi_clk = 1'b0;
    logic              pi_rst = 1'b1;
    logic              pi_sync = 1'b0;
    logic              pi_cfg_valid = 1'b0;
    logic              po_cfg_ready;
    logic [3:0]        pi_cfg_ch = '0;
    logic [1:0]        pi_cfg_mode = '0;
    logic [CNT_W-1:0]  pi_cfg_period = '0;
    logic [CNT_W-1:0]  pi_cfg_duty = '0;
    logic              po_cfg_err;
    logic [NUM_CH-1:0] po_led;
    logic [NUM_CH-1:0] po_wrap;

    always #5 pi_clk = ~pi_clk;

    led_pattern_generator #(
        .NUM_CH         (NUM_CH),
        .CNT_W          (CNT_W),
        .DEFAULT_PERIOD (DEF_PER)
    ) dut (
        .pi_clk        (pi_clk),
        .pi_rst        (pi_rst),
`ifdef LED_PATTERN_SYNC_EN
        .pi_sync       (pi_sync),
`endif
        .pi_cfg_valid  (pi_cfg_valid),
        .po_cfg_ready  (po_cfg_ready),
        .pi_cfg_ch     (pi_cfg_ch),
        .pi_cfg_mode   (pi_cfg_mode),
        .pi_cfg_period (pi_cfg_period),
        .pi_cfg_duty   (pi_cfg_duty),
        .po_cfg_err    (po_cfg_err),
        .po_led        (po_led),
        .po_wrap       (po_wrap)
    );

    // Reference model: each channel is described by its configuration, the edge at which its
    // counter last restarted (t0) and the BLINK level at that moment.
    typedef struct {
        int     mode;
        longint per;
        longint duty;
    } mcfg_t;

    mcfg_t             act[NUM_CH];
    mcfg_t             sh[NUM_CH];
    longint            t0[NUM_CH];
    bit                lvl0[NUM_CH];
    bit                pend[NUM_CH];
    longint            edge_n = 0;
    logic [NUM_CH-1:0] exp_led;
    logic [NUM_CH-1:0] exp_wrap;
    logic              exp_err;
    logic              exp_ready;
    logic              obs_ready;
    bit                last_acc;
    int                checks = 0;
    int                errors = 0;

    task automatic model_edge(input bit rst, input bit acc, input int ch, input int mode,
                              input longint per, input longint duty, input bit sync);
        edge_n++;
        exp_err = !rst && acc && (ch >= NUM_CH);
        for (int c = 0; c < NUM_CH; c++) begin
            longint p, k, pos;
            bit     lvl, w, nl;
            if (rst) begin
                act[c]      = '{M_BLINK, DEF_PER, 0};
                sh[c]       = '{M_BLINK, DEF_PER, 0};
                t0[c]       = edge_n;
                lvl0[c]     = 1'b0;
                pend[c]     = 1'b0;
                exp_led[c]  = 1'b0;
                exp_wrap[c] = 1'b0;
                continue;
            end
            p   = (act[c].per == 0) ? 1 : act[c].per;
            k   = edge_n - 1 - t0[c];
            pos = k % p;
            lvl = lvl0[c] ^ ((act[c].mode == M_BLINK) && ((k / p) % 2 == 1));
            w   = (pos == p - 1);
            nl  = lvl ^ ((act[c].mode == M_BLINK) && w);
            if (sync) begin
                w  = 1'b0;
                nl = 1'b0;
            end
            exp_wrap[c] = w;
            case (act[c].mode)
                M_OFF:   exp_led[c] = 1'b0;
                M_ON:    exp_led[c] = 1'b1;
                M_BLINK: exp_led[c] = nl;
                default: exp_led[c] = (pos < act[c].duty);
            endcase
            if (sync || (pend[c] && (act[c].mode < M_BLINK || w))) begin
                t0[c]   = edge_n;
                lvl0[c] = nl;
                if (pend[c]) begin
                    act[c]  = sh[c];
                    pend[c] = 1'b0;
                end
            end
            if (acc && ch == c) begin
                sh[c]   = '{mode, per, duty};
                pend[c] = 1'b1;
            end
        end
    endtask

    // Drives one cycle of inputs, clocks the DUT and the model, and returns at the falling edge.
    task automatic step(input bit rst, input bit valid, input int ch, input int mode,
                        input longint per, input longint duty, input bit sync);
        pi_rst        = rst;
        pi_cfg_valid  = valid;
        pi_cfg_ch     = 4'(ch);
        pi_cfg_mode   = 2'(mode);
        pi_cfg_period = CNT_W'(per);
        pi_cfg_duty   = CNT_W'(duty);
        pi_sync       = sync;
        #1;
        obs_ready = po_cfg_ready;
        exp_ready = (ch >= NUM_CH) ? 1'b1 : !pend[ch];
        last_acc  = valid && exp_ready;
        @(posedge pi_clk);
        model_edge(rst, last_acc, ch, mode, per, duty, sync);
        @(negedge pi_clk);
        pi_cfg_valid = 1'b0;
        pi_sync      = 1'b0;
    endtask

    task automatic test_reset();
        int first_rise = -1;
        int wraps = 0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({po_led, po_wrap, po_cfg_err, obs_ready} !== {exp_led, exp_wrap, exp_err, exp_ready}) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: led/wrap/err/rdy got %b %b %b %b expected %b %b %b %b",
                         i, po_led, po_wrap, po_cfg_err, obs_ready, exp_led, exp_wrap, exp_err, exp_ready);
            end
        end
        for (int i = 1; i <= 40; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({po_led, po_wrap, po_cfg_err, obs_ready} !== {exp_led, exp_wrap, exp_err, exp_ready}) begin
                errors++;
                $display("FAIL default_blink cyc %0d: led/wrap/err/rdy got %b %b %b %b expected %b %b %b %b",
                         i, po_led, po_wrap, po_cfg_err, obs_ready, exp_led, exp_wrap, exp_err, exp_ready);
            end
            if (po_led[0] && first_rise < 0) first_rise = i;
            wraps += int'(po_wrap[0]);
        end
        checks++;
        if (first_rise != DEF_PER) begin
            errors++;
            $display("FAIL first_toggle: got cycle %0d expected cycle %0d", first_rise, DEF_PER);
        end
        checks++;
        if (wraps != 40 / DEF_PER) begin
            errors++;
            $display("FAIL wrap_count: got %0d expected %0d", wraps, 40 / DEF_PER);
        end
    endtask

    task automatic test_pwm_apply();
        int highs = 0;
        step(0, 1, 1, M_PWM, 8, 3, 0);
        for (int i = 0; i < 40; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({po_led, po_wrap, po_cfg_err, obs_ready} !== {exp_led, exp_wrap, exp_err, exp_ready}) begin
                errors++;
                $display("FAIL pwm_apply cyc %0d: led/wrap/err/rdy got %b %b %b %b expected %b %b %b %b",
                         i, po_led, po_wrap, po_cfg_err, obs_ready, exp_led, exp_wrap, exp_err, exp_ready);
            end
            if (i >= 24) highs += int'(po_led[1]);
        end
        checks++;
        if (highs != 6) begin
            errors++;
            $display("FAIL pwm_duty_3_of_8: got %0d high cycles in 16 expected 6", highs);
        end
    endtask

    task automatic test_pwm_duty_edges();
        int highs;
        int wraps;
        for (int pass = 0; pass < 2; pass++) begin
            highs = 0;
            wraps = 0;
            step(0, 1, 2, M_PWM, 8, (pass == 0) ? 0 : 10, 0);
            for (int i = 0; i < 30; i++) begin
                step(0, 0, 0, 0, 0, 0, 0);
                checks++;
                if ({po_led, po_wrap, po_cfg_err, obs_ready} !== {exp_led, exp_wrap, exp_err, exp_ready}) begin
                    errors++;
                    $display("FAIL pwm_edge%0d cyc %0d: led/wrap/err/rdy got %b %b %b %b expected %b %b %b %b",
                             pass, i, po_led, po_wrap, po_cfg_err, obs_ready,
                             exp_led, exp_wrap, exp_err, exp_ready);
                end
                if (i >= 14) begin
                    highs += int'(po_led[2]);
                    wraps += int'(po_wrap[2]);
                end
            end
            checks++;
            if (highs != ((pass == 0) ? 0 : 16) || wraps != 2) begin
                errors++;
                $display("FAIL pwm_edge%0d_level: got highs %0d wraps %0d expected highs %0d wraps 2",
                         pass, highs, wraps, (pass == 0) ? 0 : 16);
            end
        end
    endtask

    task automatic test_back_to_back();
        int wait_cycles;
        int wait2 = 0;
        step(0, 1, 0, M_BLINK, 1000, 0, 0);
        for (int w = 0; w < 2; w++) begin
            wait_cycles = 0;
            last_acc = 1'b0;
            while (!last_acc && wait_cycles < 1100) begin
                step(0, 1, 0, (w == 0) ? M_PWM : M_ON, 4, 2, 0);
                wait_cycles++;
                checks++;
                if ({po_led, po_wrap, po_cfg_err, obs_ready} !== {exp_led, exp_wrap, exp_err, exp_ready}) begin
                    errors++;
                    $display("FAIL back_to_back%0d cyc %0d: led/wrap/err/rdy got %b %b %b %b expected %b %b %b %b",
                             w, wait_cycles, po_led, po_wrap, po_cfg_err, obs_ready,
                             exp_led, exp_wrap, exp_err, exp_ready);
                end
            end
            checks++;
            if (!last_acc) begin
                errors++;
                $display("FAIL back_to_back%0d_timeout: got no accept expected accept within 1100 cycles", w);
            end
            if (w == 1) wait2 = wait_cycles;
        end
        checks++;
        if (wait2 < 990 || wait2 > 1010) begin
            errors++;
            $display("FAIL blocked_by_long_period: got %0d wait cycles expected about 1000", wait2);
        end
    endtask

    task automatic test_cfg_err();
        int pulses = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 0)      step(0, 1, NUM_CH, M_ON, 3, 1, 0);
            else if (i == 1) step(0, 1, 15, M_OFF, 3, 1, 0);
            else             step(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({po_led, po_wrap, po_cfg_err, obs_ready} !== {exp_led, exp_wrap, exp_err, exp_ready}) begin
                errors++;
                $display("FAIL cfg_err cyc %0d: led/wrap/err/rdy got %b %b %b %b expected %b %b %b %b",
                         i, po_led, po_wrap, po_cfg_err, obs_ready, exp_led, exp_wrap, exp_err, exp_ready);
            end
            pulses += int'(po_cfg_err);
        end
        checks++;
        if (pulses != 2) begin
            errors++;
            $display("FAIL cfg_err_pulses: got %0d expected 2", pulses);
        end
    endtask

    task automatic test_reset_midop();
        step(0, 1, 3, M_ON, 7, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 14; i++) begin
            step(0, 0, 3, 0, 0, 0, 0);
            checks++;
            if ({po_led, po_wrap, po_cfg_err, obs_ready} !== {exp_led, exp_wrap, exp_err, exp_ready}) begin
                errors++;
                $display("FAIL reset_midop cyc %0d: led/wrap/err/rdy got %b %b %b %b expected %b %b %b %b",
                         i, po_led, po_wrap, po_cfg_err, obs_ready, exp_led, exp_wrap, exp_err, exp_ready);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            bit sync = 1'b0;
`ifdef LED_PATTERN_SYNC_EN
            sync = ($urandom_range(0, 49) == 0);
`endif
            step(0, ($urandom_range(0, 2) == 0), int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                 longint'($urandom_range(0, 12)), longint'($urandom_range(0, 14)), sync);
            checks++;
            if ({po_led, po_wrap, po_cfg_err, obs_ready} !== {exp_led, exp_wrap, exp_err, exp_ready}) begin
                errors++;
                $display("FAIL random cyc %0d: led/wrap/err/rdy got %b %b %b %b expected %b %b %b %b",
                         i, po_led, po_wrap, po_cfg_err, obs_ready, exp_led, exp_wrap, exp_err, exp_ready);
            end
        end
    endtask

`ifdef LED_PATTERN_SYNC_EN
    task automatic test_sync();
        int first_wrap[3] = '{-1, -1, -1};
        step(0, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 3; c++) step(0, 1, c, M_BLINK, 3 + c, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1);
        for (int i = 1; i <= 6; i++) begin
            step(0, 0, 0, 0, 0, 0, 0);
            checks++;
            if ({po_led, po_wrap, po_cfg_err, obs_ready} !== {exp_led, exp_wrap, exp_err, exp_ready}) begin
                errors++;
                $display("FAIL sync cyc %0d: led/wrap/err/rdy got %b %b %b %b expected %b %b %b %b",
                         i, po_led, po_wrap, po_cfg_err, obs_ready, exp_led, exp_wrap, exp_err, exp_ready);
            end
            for (int c = 0; c < 3; c++) begin
                if (po_wrap[c] && first_wrap[c] < 0) first_wrap[c] = i;
            end
        end
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (first_wrap[c] != 3 + c) begin
                errors++;
                $display("FAIL sync_wrap_ch%0d: got cycle %0d expected cycle %0d", c, first_wrap[c], 3 + c);
            end
        end
    endtask
`endif

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_pwm_apply();
        test_pwm_duty_edges();
        test_back_to_back();
        test_cfg_err();
        test_reset_midop();
        test_random();
`ifdef LED_PATTERN_SYNC_EN
        test_sync();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
